// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the oversampling UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int OS_RATE    = 16;
  localparam int OS_S0      = 7;
  localparam int OS_S1      = 8;
  localparam int OS_S2      = 9;
  localparam int DATA_W_MAX = 9;
  localparam int DATA_W_MIN = 5;
  localparam int ENTRY_W    = DATA_W_MAX + 2;

  // FIFO entry layout: {ferr, perr, data}
  typedef struct packed {
    logic                  ferr;
    logic                  perr;
    logic [DATA_W_MAX-1:0] data;
  } rx_entry_t;

  function automatic logic [3:0] clamp_bits(input logic [3:0] bits);
    if (bits < 4'(DATA_W_MIN)) return 4'(DATA_W_MIN);
    if (bits > 4'(DATA_W_MAX)) return 4'(DATA_W_MAX);
    return bits;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - show-ahead synchronous FIFO for received frames
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 11
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          wr_ok, rd_ok;

  assign valid_o = (count != '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign rd_ok   = rd_en_i && valid_o;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_ok   = wr_en_i && (!full_o || rd_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wptr] <= wr_data_i;
  end

  assign rd_data_o = valid_o ? mem[rptr] : '0;
  assign level_o   = count;

endmodule

// File: rtl/uart_rx_os_fifo.sv
// rtl/uart_rx_os_fifo.sv - 16x oversampling UART receiver with frame FIFO
// Optional break detection: UART_RX_BREAK_DET_EN
module uart_rx_os_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          rx_i,
  input  logic [DIV_W-1:0]              div_i,
  input  logic [3:0]                    data_bits_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic                          rd_en_i,
  output logic                          valid_o,
  output logic [8:0]                    rd_data_o,
  output logic                          rd_perr_o,
  output logic                          rd_ferr_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o,
  input  logic                          clr_overrun_i,
  output logic                          break_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev, fall;
  rx_state_e              state_q, state_d;
  logic [DIV_W-1:0]       div_cnt;
  logic [3:0]             phase, bit_cnt, nbits_q;
  logic                   s0, s1, maj, tick, at_s2, at_end;
  logic                   par_en_q, par_odd_q, stop2_q, stop_cnt, par_bit, ferr_q;
  logic [8:0]             shreg;
  logic                   done, push, ferr_d, perr, full, pop;
  rx_entry_t              wr_entry, rd_entry;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev <= rx_s;
    end
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign fall   = rx_prev && !rx_s;
  assign tick   = (state_q != IDLE) && (div_cnt == div_i);
  assign at_s2  = tick && (phase == 4'(OS_S2));
  assign at_end = tick && (phase == 4'(OS_RATE - 1));
  assign maj    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign ferr_d = ferr_q | ~maj;
  assign perr   = par_en_q & (^shreg ^ par_bit ^ par_odd_q);
  assign done   = (state_q == STOP) && at_s2 && (stop_cnt == stop2_q) && en_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (en_i && fall) state_d = START;
      START:  if (at_s2 && maj) state_d = IDLE;
              else if (at_end)  state_d = DATA;
      DATA:   if (at_end && bit_cnt == nbits_q - 4'd1)
                state_d = par_en_q ? PARITY : STOP;
      PARITY: if (at_end) state_d = STOP;
      STOP:   if (at_s2 && stop_cnt == stop2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!en_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt   <= '0;
      phase     <= '0;
      s0        <= 1'b0;
      s1        <= 1'b0;
      bit_cnt   <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_cnt  <= 1'b0;
      par_bit   <= 1'b0;
      ferr_q    <= 1'b0;
      shreg     <= '0;
    end else if (state_q == IDLE) begin
      div_cnt  <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      ferr_q   <= 1'b0;
      shreg    <= '0;
      if (en_i && fall) begin
        nbits_q   <= clamp_bits(data_bits_i);
        par_en_q  <= parity_en_i;
        par_odd_q <= parity_odd_i;
        stop2_q   <= stop2_i;
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) phase <= phase + 4'd1;
      if (tick && phase == 4'(OS_S0)) s0 <= rx_s;
      if (tick && phase == 4'(OS_S1)) s1 <= rx_s;
      if (at_s2) begin
        case (state_q)
          DATA:    shreg[bit_cnt] <= maj;
          PARITY:  par_bit <= maj;
          STOP:    ferr_q <= ferr_d;
          default: ;
        endcase
      end
      if (at_end && state_q == DATA) bit_cnt  <= bit_cnt + 4'd1;
      if (at_end && state_q == STOP) stop_cnt <= 1'b1;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic stop1_zero, brk, brk_q;
  // on the second stop bit, ferr_q holds exactly the first stop bit's result
  assign stop1_zero = stop_cnt ? ferr_q : ~maj;
  assign brk        = (shreg == '0) && !(par_en_q && par_bit) && stop1_zero;
  assign push       = done && !brk;

  always_ff @(posedge clk_i) begin
    if (rst_i) brk_q <= 1'b0;
    else       brk_q <= done && brk;
  end
  assign break_o = brk_q;
`else
  assign push    = done;
  assign break_o = 1'b0;
`endif

  assign pop      = rd_en_i && valid_o;
  assign wr_entry = '{ferr: ferr_d, perr: perr, data: shreg};

  always_ff @(posedge clk_i) begin
    if (rst_i)                      overrun_o <= 1'b0;
    else if (push && full && !pop)  overrun_o <= 1'b1;
    else if (clr_overrun_i)         overrun_o <= 1'b0;
  end

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_en_i   (rd_en_i),
    .rd_data_o (rd_entry),
    .valid_o   (valid_o),
    .full_o    (full),
    .level_o   (level_o)
  );

  assign rd_data_o = rd_entry.data;
  assign rd_perr_o = rd_entry.perr;
  assign rd_ferr_o = rd_entry.ferr;

endmodule
